mem_access_unit: RTL and testbench

Parametrised RV32I load/store unit between the execute stage and the data-memory port. It accepts one load/store request at a time and checks alignment and funct3. It generates a word-aligned address, byte mask and lane-shifted write data, waits on a variable-latency memory with a ready/rvalid handshake, then sign- or zero-extends load data. A timeout counter, error codes and a busy output let the pipeline stall and trap.

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/lsu_align.sv | 59 +++++
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants and types for the RV32I load/store unit.
// Holds the funct3 encodings, response error codes and the FSM state type.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_RESP
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask, store-data lane shift, legality checks
// and load-data extraction with sign/zero extension.
module lsu_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic              write,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] mask,
  output logic [XLEN-1:0]   wdata_lane,
  output logic              misalign,
  output logic              illegal,
  output logic [XLEN-1:0]   load_data
);

  logic [1:0]      size;
  logic [XLEN-1:0] rdata_shifted;

  assign size = funct3[1:0];

  // A lane is enabled if it lies inside [offset, offset + access size).
  for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
    assign mask[gi] = (size == 2'b10)
                   || (gi == int'(offset))
                   || ((size == 2'b01) && (gi == int'(offset) + 1));
  end

  assign wdata_lane    = wdata << {offset, 3'b000};
  assign rdata_shifted = rdata >> {offset, 3'b000};

  assign misalign = ((size == 2'b01) && offset[0])
                 || ((size == 2'b10) && (offset != 2'b00));

  always_comb begin
    illegal = 1'b0;
    if (write) begin
      illegal = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
    end else begin
      illegal = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W)
               || (funct3 == F3_BU) || (funct3 == F3_HU));
    end
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, rdata_shifted[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, rdata_shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store unit: accepts one request, drives a ready-handshaked data
// memory port, waits for read data with a timeout, and returns one response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [2:0]        i_req_funct3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_resp_valid,
  output logic [XLEN-1:0]   o_resp_rdata,
  output logic [1:0]        o_resp_err,
  output logic              o_busy,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic              o_dmem_ren,
  output logic              o_dmem_wen,
  output logic [XLEN-1:0]   o_dmem_wdata,
  output logic [XLEN/8-1:0] o_dmem_mask,
  input  logic              i_dmem_ready,
  input  logic              i_dmem_rvalid,
  input  logic [XLEN-1:0]   i_dmem_rdata
);

  localparam int MW = XLEN/8;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t          state_reg, state_next;
  logic [2:0]      funct3_reg, funct3_next;
  logic [1:0]      off_reg, off_next;
  logic            write_reg, write_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic            ren_reg, ren_next;
  logic            wen_reg, wen_next;
  logic [XLEN-1:0] wdata_reg, wdata_next;
  logic [MW-1:0]   mask_reg, mask_next;
  logic [XLEN-1:0] rdata_reg, rdata_next;
  logic [1:0]      err_reg, err_next;
  logic [TW-1:0]   tcnt_reg, tcnt_next;

  logic            complete;
  logic            timeout_hit;
  logic [2:0]      al_funct3;
  logic [1:0]      al_offset;
  logic            al_write;
  logic [MW-1:0]   al_mask;
  logic [XLEN-1:0] al_wdata_lane;
  logic            al_misalign;
  logic            al_illegal;
  logic [XLEN-1:0] al_load_data;

  // The single aligner checks the incoming request in IDLE and extracts load
  // data from the latched access parameters in every other state.
  assign al_funct3 = (state_reg == ST_IDLE) ? i_req_funct3 : funct3_reg;
  assign al_offset = (state_reg == ST_IDLE) ? i_addr[1:0]  : off_reg;
  assign al_write  = (state_reg == ST_IDLE) ? i_req_write  : write_reg;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_funct3),
    .offset     (al_offset),
    .write      (al_write),
    .wdata      (i_wdata),
    .rdata      (i_dmem_rdata),
    .mask       (al_mask),
    .wdata_lane (al_wdata_lane),
    .misalign   (al_misalign),
    .illegal    (al_illegal),
    .load_data  (al_load_data)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((int'(tcnt_reg) + 1) >= TIMEOUT_CYCLES);

  always_comb begin
    state_next  = state_reg;
    funct3_next = funct3_reg;
    off_next    = off_reg;
    write_next  = write_reg;
    addr_next   = addr_reg;
    ren_next    = ren_reg;
    wen_next    = wen_reg;
    wdata_next  = wdata_reg;
    mask_next   = mask_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    tcnt_next   = tcnt_reg;
    complete    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_req_valid) begin
          funct3_next = i_req_funct3;
          off_next    = i_addr[1:0];
          write_next  = i_req_write;
          rdata_next  = '0;
          if (al_illegal) begin
            err_next   = ERR_ILLEGAL;
            state_next = ST_RESP;
          end else if (al_misalign) begin
            err_next   = ERR_MISALIGN;
            state_next = ST_RESP;
          end else begin
            err_next   = ERR_OK;
            addr_next  = {i_addr[XLEN-1:2], 2'b00};
            mask_next  = al_mask;
            wdata_next = al_wdata_lane;
            ren_next   = !i_req_write;
            wen_next   = i_req_write;
            tcnt_next  = '0;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (i_dmem_ready) begin
          ren_next = 1'b0;
          wen_next = 1'b0;
          if (write_reg) begin
            complete   = 1'b1;
            state_next = ST_RESP;
          end else if (i_dmem_rvalid) begin
            complete   = 1'b1;
            rdata_next = al_load_data;
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (i_dmem_rvalid) begin
          complete   = 1'b1;
          rdata_next = al_load_data;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // A completion in the limit cycle takes priority over the timeout.
    if (((state_reg == ST_ISSUE) || (state_reg == ST_WAIT_RD)) && !complete) begin
      if (timeout_hit) begin
        state_next = ST_RESP;
        err_next   = ERR_TIMEOUT;
        rdata_next = '0;
        ren_next   = 1'b0;
        wen_next   = 1'b0;
      end else begin
        tcnt_next = tcnt_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      funct3_reg <= '0;
      off_reg    <= '0;
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      ren_reg    <= 1'b0;
      wen_reg    <= 1'b0;
      wdata_reg  <= '0;
      mask_reg   <= '0;
      rdata_reg  <= '0;
      err_reg    <= '0;
      tcnt_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      funct3_reg <= funct3_next;
      off_reg    <= off_next;
      write_reg  <= write_next;
      addr_reg   <= addr_next;
      ren_reg    <= ren_next;
      wen_reg    <= wen_next;
      wdata_reg  <= wdata_next;
      mask_reg   <= mask_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
      tcnt_reg   <= tcnt_next;
    end
  end

  assign o_req_ready  = (state_reg == ST_IDLE);
  assign o_busy       = (state_reg != ST_IDLE);
  assign o_resp_valid = (state_reg == ST_RESP);
  assign o_resp_rdata = rdata_reg;
  assign o_resp_err   = err_reg;
  assign o_dmem_addr  = addr_reg;
  assign o_dmem_ren   = ren_reg;
  assign o_dmem_wen   = wen_reg;
  assign o_dmem_wdata = wdata_reg;
  assign o_dmem_mask  = mask_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a short timeout limit of 4 cycles.
// Expected responses are queued at request time and compared as they appear.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [2:0]  i_req_funct3 = 3'b000;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic [1:0]  o_resp_err;
  logic        o_busy;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_ren;
  logic        o_dmem_wen;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        i_dmem_ready = 1'b0;
  logic        i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = '0;

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_write   (i_req_write),
    .i_req_funct3  (i_req_funct3),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .o_resp_valid  (o_resp_valid),
    .o_resp_rdata  (o_resp_rdata),
    .o_resp_err    (o_resp_err),
    .o_busy        (o_busy),
    .o_dmem_addr   (o_dmem_addr),
    .o_dmem_ren    (o_dmem_ren),
    .o_dmem_wen    (o_dmem_wen),
    .o_dmem_wdata  (o_dmem_wdata),
    .o_dmem_mask   (o_dmem_mask),
    .i_dmem_ready  (i_dmem_ready),
    .i_dmem_rvalid (i_dmem_rvalid),
    .i_dmem_rdata  (i_dmem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_illegal(input logic w, input logic [2:0] f3);
    if (w) return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic logic m_misalign(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'd1) && off[0]) || ((f3[1:0] == 2'd2) && (off != 2'd0));
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: return 4'b1111;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && o_resp_valid) begin
      $display("resp cyc=%0d rdata=0x%08h err=%0d", cyc, o_resp_rdata, o_resp_err);
      if (sb.size() == 0) begin
        check_eq("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("resp_rdata", o_resp_rdata, e.rdata);
        check_eq("resp_err", {30'd0, o_resp_err}, {30'd0, e.err});
        check_eq("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // ready_at/rvalid_at are cycles after acceptance (0 = never asserted).
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ready_at, input int rvalid_at,
                         input logic [31:0] rdata);
    logic [1:0]  off;
    logic [1:0]  err;
    logic [31:0] exp_rd;
    int          comp, lat, strobe_end;
    bit          done;
    off  = addr[1:0];
    comp = w ? ready_at : ((ready_at == 0) ? 0 : rvalid_at);
    if (m_illegal(w, f3))      begin err = 2'b11; lat = 1; end
    else if (m_misalign(f3, off)) begin err = 2'b01; lat = 1; end
    else if (comp == 0 || comp > TMO) begin err = 2'b10; lat = TMO + 1; end
    else begin err = 2'b00; lat = comp + 1; end
    exp_rd = (err == 2'b00 && !w) ? m_ext(f3, off, rdata) : 32'd0;
    strobe_end = (err == 2'b00 || err == 2'b10) ?
                 ((ready_at == 0 || ready_at > TMO) ? TMO : ready_at) : 0;

    @(negedge clk);
    check_eq("req_ready", {31'd0, o_req_ready}, 32'd1);
    i_req_valid  = 1'b1;
    i_req_write  = w;
    i_req_funct3 = f3;
    i_addr       = addr;
    i_wdata      = wdata;
    sb.push_back('{exp_rd, err, cyc + lat});
    done = 1'b0;
    for (int c = 1; c <= 12 && !done; c++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      check_eq("dmem_ren", {31'd0, o_dmem_ren}, {31'd0, (!w && c <= strobe_end)});
      check_eq("dmem_wen", {31'd0, o_dmem_wen}, {31'd0, (w && c <= strobe_end)});
      if (c == 1 && strobe_end > 0) begin
        check_eq("dmem_addr", o_dmem_addr, {addr[31:2], 2'b00});
        check_eq("dmem_mask", {28'd0, o_dmem_mask}, {28'd0, m_mask(f3, off)});
        if (w) check_eq("dmem_wdata", o_dmem_wdata, wdata << (8 * off));
      end
      if (o_resp_valid) done = 1'b1;
      i_dmem_ready  = (c == ready_at);
      i_dmem_rvalid = (c == rvalid_at);
      i_dmem_rdata  = rdata;
    end
    i_dmem_ready  = 1'b0;
    i_dmem_rvalid = 1'b0;
    if (!done) check_eq("resp_seen", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    int          ra;
    repeat (2) @(negedge clk);
    check_eq("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_ren", {31'd0, o_dmem_ren}, 32'd0);
    check_eq("rst_dmem_addr", o_dmem_addr, 32'd0);
    check_eq("rst_rdata", o_resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", {31'd0, o_req_ready}, 32'd1);

    run_req(1'b0, 3'b000, 32'h0000_1003, 32'h0, 1, 4, 32'h80FF_FF00);  // LB, done at limit
    run_req(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1, 0, 32'h0);  // SH
    run_req(1'b0, 3'b010, 32'h0000_3001, 32'h0, 1, 1, 32'h0);          // LW misaligned
    run_req(1'b1, 3'b100, 32'h0000_3000, 32'h0, 1, 0, 32'h0);          // store funct3 100
    run_req(1'b0, 3'b101, 32'h0000_4002, 32'h0, 1, 1, 32'h8001_0000);  // LHU
    run_req(1'b0, 3'b010, 32'h0000_5000, 32'h0, 0, 0, 32'h0);          // timeout

    // Stray handshake in IDLE must not produce a response.
    @(negedge clk);
    i_dmem_rvalid = 1'b1;
    i_dmem_ready  = 1'b1;
    @(negedge clk);
    check_eq("stray_no_resp", {31'd0, o_resp_valid}, 32'd0);
    check_eq("stray_busy", {31'd0, o_busy}, 32'd0);
    i_dmem_rvalid = 1'b0;
    i_dmem_ready  = 1'b0;

    // Reset while waiting for read data.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_funct3 = 3'b010; i_addr = 32'h0000_7000;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_dmem_ready = 1'b1;
    @(negedge clk);
    i_dmem_ready = 1'b0;
    check_eq("wait_rd_busy", {31'd0, o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_ren", {31'd0, o_dmem_ren}, 32'd0);
    check_eq("midrst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("midrst_addr", o_dmem_addr, 32'd0);
    check_eq("midrst_mask", {28'd0, o_dmem_mask}, 32'd0);
    $display("reset asserted during WAIT_RD at cyc=%0d", cyc);
    @(negedge clk);
    rst_n = 1'b1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    i_dmem_rvalid = 1'b0;
    check_eq("post_rst_no_resp", {31'd0, o_resp_valid}, 32'd0);
    check_eq("post_rst_busy", {31'd0, o_busy}, 32'd0);

    run_req(1'b1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 3, 0, 32'h0);  // SB, late ready

    for (int i = 0; i < 24; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        f3 = w ? 3'($urandom_range(0, 2)) : ((i % 2 == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      ra = $urandom_range(1, 3);
      run_req(w, f3, a, $urandom(), ra, ra + $urandom_range(0, 2), $urandom());
    end

    repeat (2) @(negedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
